// File: rtl/uart_mmio.sv
// ---------------------------------------------------------------------------
// uart_mmio
// Memory-mapped console device. It answers the core's RAM-style request port
// inside a 32-byte window. Outgoing characters are buffered in a TX FIFO and
// drained to the UART pins with a fixed gap between them. Incoming characters
// are fetched by periodic polls of the simulator and buffered in an RX FIFO.
//
// Register map (addr[4:3], addr[2:0] ignored):
//   0 TXDATA : write pushes wdata[7:0] when wmask[7:0] is all ones; reads 0
//   1 RXDATA : read pops and returns the RX head; returns 0 when empty
//   2 STATUS : {rx_ovf, tx_ovf, rx_full, rx_nonempty, tx_empty, tx_full}
//              bits 4/5 are write-one-to-clear (wmask[7:0] all ones)
//   3 reserved
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_ren/i_raddr       read request and byte address
//   o_rdata/o_rvalid    registered read data, valid one cycle after request
//   i_wen/i_waddr       write request and byte address
//   i_wdata/i_wmask     write data and per-bit write mask
//   o_uart_out_valid    one-cycle pulse, character on o_uart_out_ch
//   o_uart_out_ch       outgoing character
//   o_uart_in_valid     one-cycle poll request to the simulator
//   i_uart_in_ch        character answered during the poll, 8'hFF means none
//   o_irq               rx not empty or any sticky overflow flag set
// ---------------------------------------------------------------------------
module uart_mmio #(
    parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_1000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          TX_GAP     = 4,
    parameter int          RX_POLL    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_ren,
    input  logic [63:0] i_raddr,
    output logic [63:0] o_rdata,
    output logic        o_rvalid,
    input  logic        i_wen,
    input  logic [63:0] i_waddr,
    input  logic [63:0] i_wdata,
    input  logic [63:0] i_wmask,
    output logic        o_uart_out_valid,
    output logic [7:0]  o_uart_out_ch,
    output logic        o_uart_in_valid,
    input  logic [7:0]  i_uart_in_ch,
    output logic        o_irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;
    localparam int PW = (RX_POLL > 1) ? $clog2(RX_POLL) : 1;

    localparam logic [GW-1:0] GAP_LOAD  = GW'(TX_GAP);
    localparam logic [PW-1:0] POLL_LOAD = PW'(RX_POLL - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } txState_t;

    // FIFO storage and pointers (extra top bit is the wrap bit)
    logic [7:0]    r_txMem [FIFO_DEPTH];
    logic [7:0]    r_rxMem [FIFO_DEPTH];
    logic [CW-1:0] r_txWr;
    logic [CW-1:0] r_txRd;
    logic [CW-1:0] r_rxWr;
    logic [CW-1:0] r_rxRd;

    logic          r_txOvf;
    logic          r_rxOvf;
    logic [63:0]   r_rdata;
    logic          r_rvalid;

    txState_t      r_txState;
    logic [GW-1:0] r_gap;
    logic          r_outValid;
    logic [7:0]    r_outCh;

    logic [PW-1:0] r_poll;
    logic          r_inValid;

    logic          w_rHit;
    logic          w_wHit;
    logic [1:0]    w_rSel;
    logic [1:0]    w_wSel;
    logic          w_wByteMask;
    logic          w_txEmpty;
    logic          w_txFull;
    logic          w_rxEmpty;
    logic          w_rxFull;
    logic          w_txPushReq;
    logic          w_txPush;
    logic          w_txPop;
    logic          w_txOvfSet;
    logic          w_rxPushReq;
    logic          w_rxPush;
    logic          w_rxPop;
    logic          w_rxOvfSet;
    logic          w_stsWrite;
    logic [CW-1:0] w_rxCount;
    logic [CW-1:0] w_rxCountNext;
    logic [63:0]   w_status;
    logic          w_unused;

    // Address decode: window match on addr[63:5], register on addr[4:3]
    assign w_rHit      = i_ren && (i_raddr[63:5] == BASE_ADDR[63:5]);
    assign w_wHit      = i_wen && (i_waddr[63:5] == BASE_ADDR[63:5]);
    assign w_rSel      = i_raddr[4:3];
    assign w_wSel      = i_waddr[4:3];
    assign w_wByteMask = (i_wmask[7:0] == 8'hFF);

    assign w_txEmpty = (r_txWr == r_txRd);
    assign w_txFull  = (r_txWr[AW-1:0] == r_txRd[AW-1:0]) && (r_txWr[AW] != r_txRd[AW]);
    assign w_rxEmpty = (r_rxWr == r_rxRd);
    assign w_rxFull  = (r_rxWr[AW-1:0] == r_rxRd[AW-1:0]) && (r_rxWr[AW] != r_rxRd[AW]);

    // A push that coincides with a pop always succeeds, even when full
    assign w_txPop     = (r_txState == S_SEND);
    assign w_txPushReq = w_wHit && (w_wSel == REG_TXDATA) && w_wByteMask;
    assign w_txPush    = w_txPushReq && (!w_txFull || w_txPop);
    assign w_txOvfSet  = w_txPushReq && w_txFull && !w_txPop;

    assign w_rxPop     = w_rHit && (w_rSel == REG_RXDATA) && !w_rxEmpty;
    assign w_rxPushReq = r_inValid && (i_uart_in_ch != 8'hFF);
    assign w_rxPush    = w_rxPushReq && (!w_rxFull || w_rxPop);
    assign w_rxOvfSet  = w_rxPushReq && w_rxFull && !w_rxPop;

    assign w_stsWrite = w_wHit && (w_wSel == REG_STATUS) && w_wByteMask;

    // Occupancy after this cycle, so a poll is never issued into a full FIFO
    assign w_rxCount     = r_rxWr - r_rxRd;
    assign w_rxCountNext = w_rxCount + CW'(w_rxPush) - CW'(w_rxPop);

    assign w_status = {58'b0, r_rxOvf, r_txOvf, w_rxFull, !w_rxEmpty, w_txEmpty, w_txFull};

    assign w_unused = ^{i_raddr[2:0], i_waddr[2:0], i_wdata[63:8], i_wmask[63:8]};

    // FIFO storage needs no reset; emptiness comes from the pointers
    always_ff @(posedge clk) begin
        if (w_txPush) begin
            r_txMem[r_txWr[AW-1:0]] <= i_wdata[7:0];
        end
        if (w_rxPush) begin
            r_rxMem[r_rxWr[AW-1:0]] <= i_uart_in_ch;
        end
    end

    // FIFO pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txWr <= '0;
            r_txRd <= '0;
            r_rxWr <= '0;
            r_rxRd <= '0;
        end else begin
            if (w_txPush) r_txWr <= r_txWr + CW'(1);
            if (w_txPop)  r_txRd <= r_txRd + CW'(1);
            if (w_rxPush) r_rxWr <= r_rxWr + CW'(1);
            if (w_rxPop)  r_rxRd <= r_rxRd + CW'(1);
        end
    end

    // Sticky overflow flags; a new overflow wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txOvf <= 1'b0;
            r_rxOvf <= 1'b0;
        end else begin
            if (w_txOvfSet)                    r_txOvf <= 1'b1;
            else if (w_stsWrite && i_wdata[4]) r_txOvf <= 1'b0;
            if (w_rxOvfSet)                    r_rxOvf <= 1'b1;
            else if (w_stsWrite && i_wdata[5]) r_rxOvf <= 1'b0;
        end
    end

    // Read port: data reflects state before this cycle's updates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rHit;
            if (w_rHit) begin
                case (w_rSel)
                    REG_RXDATA: r_rdata <= w_rxEmpty ? 64'd0 : {56'b0, r_rxMem[r_rxRd[AW-1:0]]};
                    REG_STATUS: r_rdata <= w_status;
                    default:    r_rdata <= '0;
                endcase
            end
        end
    end

    // TX drain: present head for one cycle, pop it, then wait out the gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txState  <= S_IDLE;
            r_gap      <= '0;
            r_outValid <= 1'b0;
            r_outCh    <= '0;
        end else begin
            r_outValid <= 1'b0;
            case (r_txState)
                S_IDLE: begin
                    if (!w_txEmpty) begin
                        r_txState  <= S_SEND;
                        r_outValid <= 1'b1;
                        r_outCh    <= r_txMem[r_txRd[AW-1:0]];
                    end
                end
                S_SEND: begin
                    if (TX_GAP == 0) begin
                        r_txState <= S_IDLE;
                    end else begin
                        r_txState <= S_GAP;
                        r_gap     <= GAP_LOAD;
                    end
                end
                S_GAP: begin
                    if (r_gap <= GW'(1)) begin
                        r_txState <= S_IDLE;
                        r_gap     <= '0;
                    end else begin
                        r_gap <= r_gap - GW'(1);
                    end
                end
                default: begin
                    r_txState <= S_IDLE;
                end
            endcase
        end
    end

    // RX poll timer: one poll pulse per period unless the FIFO would be full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_poll    <= '0;
            r_inValid <= 1'b0;
        end else begin
            r_inValid <= 1'b0;
            if (r_poll == '0) begin
                r_poll <= POLL_LOAD;
                if (w_rxCountNext != DEPTH_CNT) begin
                    r_inValid <= 1'b1;
                end
            end else begin
                r_poll <= r_poll - PW'(1);
            end
        end
    end

    assign o_rdata          = r_rdata;
    assign o_rvalid         = r_rvalid;
    assign o_uart_out_valid = r_outValid;
    assign o_uart_out_ch    = r_outCh;
    assign o_uart_in_valid  = r_inValid;
    assign o_irq            = !w_rxEmpty || r_txOvf || r_rxOvf;

endmodule

// File: tb/tb_uart_mmio.sv
// ---------------------------------------------------------------------------
// tb_uart_mmio
// Exercises the console device through its request port and UART pins. A
// second instance with a long TX gap is used to stall the drain so the TX
// FIFO can be overfilled. Expected characters and register values come from
// queues and plain FIFO arithmetic kept in the bench.
// ---------------------------------------------------------------------------
module tb_uart_mmio;

    localparam logic [63:0] BASE = 64'h0000_0000_1000_0000;
    localparam int DEPTH    = 8;
    localparam int GAP      = 4;
    localparam int SLOW_GAP = 100;
    localparam int POLL     = 16;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        ren      = 1'b0;
    logic        wen      = 1'b0;
    logic [63:0] raddr    = '0;
    logic [63:0] waddr    = '0;
    logic [63:0] wdata    = '0;
    logic [63:0] wmask    = '0;
    logic [7:0]  uartInCh = 8'hFF;

    logic [63:0] rdata, rdataSlow;
    logic        rvalid, rvalidSlow;
    logic        outValid, outValidSlow;
    logic [7:0]  outCh, outChSlow;
    logic        inValid, inValidSlow;
    logic        irq, irqSlow;

    int checks     = 0;
    int failures   = 0;
    int cycle      = 0;
    int inPulseCnt = 0;

    logic [7:0] txObs[$];
    int         txObsCycle[$];
    logic [7:0] slowObs[$];

    uart_mmio #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .TX_GAP(GAP), .RX_POLL(POLL)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_ren(ren), .i_raddr(raddr), .o_rdata(rdata), .o_rvalid(rvalid),
        .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata), .i_wmask(wmask),
        .o_uart_out_valid(outValid), .o_uart_out_ch(outCh),
        .o_uart_in_valid(inValid), .i_uart_in_ch(uartInCh),
        .o_irq(irq)
    );

    uart_mmio #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .TX_GAP(SLOW_GAP), .RX_POLL(POLL)) dutSlow (
        .clk(clk), .rst_n(rst_n),
        .i_ren(ren), .i_raddr(raddr), .o_rdata(rdataSlow), .o_rvalid(rvalidSlow),
        .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata), .i_wmask(wmask),
        .o_uart_out_valid(outValidSlow), .o_uart_out_ch(outChSlow),
        .o_uart_in_valid(inValidSlow), .i_uart_in_ch(uartInCh),
        .o_irq(irqSlow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle = cycle + 1;

    // Record UART pin activity mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (outValid) begin
            txObs.push_back(outCh);
            txObsCycle.push_back(cycle);
        end
        if (outValidSlow) slowObs.push_back(outChSlow);
        if (inValid) inPulseCnt = inPulseCnt + 1;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=time_expired required=finish");
        $fatal(1, "[TB] simulation did not finish in time");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        ren = 1'b0;
        wen = 1'b0;
        uartInCh = 8'hFF;
        tick();
        tick();
        rst_n = 1'b1;
        inPulseCnt = 0;
    endtask

    task automatic busWrite(input logic [63:0] a, input logic [63:0] d, input logic [63:0] m);
        waddr = a;
        wdata = d;
        wmask = m;
        wen = 1'b1;
        tick();
        wen = 1'b0;
    endtask

    task automatic busRead(input logic [63:0] a);
        raddr = a;
        ren = 1'b1;
        tick();
        ren = 1'b0;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic waitInPulse(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 2 * POLL + 4; i++) begin
            tick();
            if (inValid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        uartInCh = 8'hFF;
        repeat (3) tick();
        checks++;
        if ({rdata, rvalid, outValid, outCh, inValid, irq} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs actual=%h/%b/%b/%h/%b/%b required=all zero", rdata, rvalid, outValid, outCh, inValid, irq);
        end
        checks++;
        if ({rdataSlow, rvalidSlow, outValidSlow, outChSlow, inValidSlow, irqSlow} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs_slow actual=%h/%b required=all zero", rdataSlow, irqSlow);
        end
        rst_n = 1'b1;
        busRead(BASE + 64'h10);
        checks++;
        if (rvalid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_status_rvalid actual=%b required=1", rvalid);
        end
        checks++;
        if (rdata !== 64'h2) begin
            failures++;
            $display("[TB] FAIL reset_status_rdata actual=0x%0h required=0x2", rdata);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_irq actual=%b required=0", irq);
        end
        tick();
        checks++;
        if (rvalid !== 1'b0 || rdata !== 64'h2) begin
            failures++;
            $display("[TB] FAIL rvalid_pulse_hold actual=%b/0x%0h required=0/0x2", rvalid, rdata);
        end
    endtask

    task automatic test_tx_basic();
        logic [7:0]  exp[$];
        logic [63:0] rd;
        logic [63:0] rm;
        exp = {8'h41, 8'h42};
        repeat (3) exp.push_back(8'($urandom_range(0, 255)));
        txObs.delete();
        txObsCycle.delete();
        foreach (exp[i]) begin
            rd = rnd64();
            rm = rnd64();
            busWrite(BASE, {rd[63:8], exp[i]}, {rm[63:8], 8'hFF});
        end
        for (int i = 0; i < 200 && txObs.size() < exp.size(); i++) tick();
        checks++;
        if (txObs.size() != exp.size()) begin
            failures++;
            $display("[TB] FAIL tx_count actual=%0d required=%0d", txObs.size(), exp.size());
        end
        for (int i = 0; i < txObs.size() && i < exp.size(); i++) begin
            checks++;
            if (txObs[i] !== exp[i]) begin
                failures++;
                $display("[TB] FAIL tx_char[%0d] actual=0x%0h required=0x%0h", i, txObs[i], exp[i]);
            end
        end
        for (int i = 1; i < txObsCycle.size(); i++) begin
            checks++;
            if (txObsCycle[i] - txObsCycle[i-1] != GAP + 2) begin
                failures++;
                $display("[TB] FAIL tx_spacing[%0d] actual=%0d required=%0d", i, txObsCycle[i] - txObsCycle[i-1], GAP + 2);
            end
        end
    endtask

    task automatic test_ignored();
        logic [7:0]  b;
        logic [63:0] rd;
        txObs.delete();
        busRead(BASE + 64'h10);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 64'h2) begin
            failures++;
            $display("[TB] FAIL idle_status actual=%b/0x%0h required=1/0x2", rvalid, rdata);
        end
        busRead(BASE + 64'h20);
        checks++;
        if (rvalid !== 1'b0 || rdata !== 64'h2) begin
            failures++;
            $display("[TB] FAIL window_read actual=%b/0x%0h required=0/0x2", rvalid, rdata);
        end
        busRead(BASE + 64'h18);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 64'h0) begin
            failures++;
            $display("[TB] FAIL reserved_read actual=%b/0x%0h required=1/0x0", rvalid, rdata);
        end
        busRead(BASE + 64'h3);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 64'h0) begin
            failures++;
            $display("[TB] FAIL txdata_read actual=%b/0x%0h required=1/0x0", rvalid, rdata);
        end
        busWrite(BASE, rnd64(), 64'h0F);
        busWrite(BASE + 64'h20, rnd64(), '1);
        busWrite(BASE - 64'h8, rnd64(), '1);
        busWrite(BASE + 64'h18, '1, '1);
        repeat (20) tick();
        checks++;
        if (txObs.size() != 0) begin
            failures++;
            $display("[TB] FAIL ignored_writes actual=%0d chars required=0", txObs.size());
        end
        busRead(BASE + 64'h10);
        checks++;
        if (rdata !== 64'h2 || irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ignored_status actual=0x%0h/%b required=0x2/0", rdata, irq);
        end
        b = 8'($urandom_range(0, 255));
        rd = rnd64();
        busWrite(BASE + 64'h5, {rd[63:8], b}, 64'hFF);
        repeat (20) tick();
        checks++;
        if (txObs.size() != 1 || txObs[0] !== b) begin
            failures++;
            $display("[TB] FAIL low_addr_bits actual=%0d chars required=1 char 0x%0h", txObs.size(), b);
        end
    endtask

    task automatic test_tx_overflow();
        logic [7:0]  bytes[$];
        logic [63:0] rd;
        doReset();
        slowObs.delete();
        repeat (12) bytes.push_back(8'($urandom_range(0, 255)));
        foreach (bytes[i]) begin
            rd = rnd64();
            busWrite(BASE, {rd[63:8], bytes[i]}, 64'hFF);
        end
        busRead(BASE + 64'h10);
        checks++;
        if (rdataSlow !== 64'h11 || irqSlow !== 1'b1) begin
            failures++;
            $display("[TB] FAIL tx_ovf_status actual=0x%0h/%b required=0x11/1", rdataSlow, irqSlow);
        end
        busWrite(BASE + 64'h10, 64'h10, 64'h0F);
        busRead(BASE + 64'h10);
        checks++;
        if (rdataSlow !== 64'h11) begin
            failures++;
            $display("[TB] FAIL w1c_partial_mask actual=0x%0h required=0x11", rdataSlow);
        end
        raddr = BASE + 64'h10;
        ren = 1'b1;
        waddr = BASE + 64'h10;
        wdata = 64'h10;
        wmask = 64'hFF;
        wen = 1'b1;
        tick();
        ren = 1'b0;
        wen = 1'b0;
        checks++;
        if (rdataSlow !== 64'h11) begin
            failures++;
            $display("[TB] FAIL status_same_cycle actual=0x%0h required=0x11", rdataSlow);
        end
        busRead(BASE + 64'h10);
        checks++;
        if (rdataSlow !== 64'h01 || irqSlow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL w1c_clear actual=0x%0h/%b required=0x1/0", rdataSlow, irqSlow);
        end
        for (int i = 0; i < 1100 && slowObs.size() < 9; i++) tick();
        repeat (120) tick();
        checks++;
        if (slowObs.size() != 9) begin
            failures++;
            $display("[TB] FAIL ovf_drain_count actual=%0d required=9", slowObs.size());
        end
        for (int i = 0; i < slowObs.size() && i < 9; i++) begin
            checks++;
            if (slowObs[i] !== bytes[i]) begin
                failures++;
                $display("[TB] FAIL ovf_drain[%0d] actual=0x%0h required=0x%0h", i, slowObs[i], bytes[i]);
            end
        end
        busRead(BASE + 64'h10);
        checks++;
        if (rdataSlow !== 64'h2) begin
            failures++;
            $display("[TB] FAIL ovf_final_status actual=0x%0h required=0x2", rdataSlow);
        end
    endtask

    task automatic test_rx_basic();
        logic [7:0] vals[5];
        logic [7:0] model[$];
        logic [63:0] expSts;
        bit seen;
        doReset();
        vals[0] = 8'hFF;
        vals[1] = 8'h61;
        for (int i = 2; i < 5; i++) vals[i] = 8'($urandom_range(0, 255));
        foreach (vals[i]) begin
            uartInCh = vals[i];
            waitInPulse(seen);
            checks++;
            if (!seen) begin
                failures++;
                $display("[TB] FAIL rx_poll_timeout[%0d] actual=no pulse required=pulse", i);
            end
            tick();
            uartInCh = 8'hFF;
            if (vals[i] != 8'hFF) model.push_back(vals[i]);
        end
        expSts = 64'h2 | ((model.size() > 0) ? 64'h4 : 64'h0);
        busRead(BASE + 64'h10);
        checks++;
        if (rdata !== expSts || irq !== (model.size() > 0)) begin
            failures++;
            $display("[TB] FAIL rx_status actual=0x%0h/%b required=0x%0h/%b", rdata, irq, expSts, model.size() > 0);
        end
        while (model.size() > 0) begin
            logic [7:0] e;
            e = model.pop_front();
            busRead(BASE + 64'h8);
            checks++;
            if (rvalid !== 1'b1 || rdata !== {56'b0, e}) begin
                failures++;
                $display("[TB] FAIL rxdata actual=%b/0x%0h required=1/0x%0h", rvalid, rdata, e);
            end
        end
        busRead(BASE + 64'h10);
        checks++;
        if (rdata !== 64'h2 || irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rx_drained_status actual=0x%0h/%b required=0x2/0", rdata, irq);
        end
        busRead(BASE + 64'h8);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 64'h0) begin
            failures++;
            $display("[TB] FAIL rx_empty_read actual=%b/0x%0h required=1/0x0", rvalid, rdata);
        end
    endtask

    task automatic test_rx_full();
        logic [7:0] v;
        doReset();
        v = 8'($urandom_range(0, 254));
        uartInCh = v;
        for (int i = 0; i < 8 * POLL + 40 && inPulseCnt < DEPTH; i++) tick();
        repeat (3 * POLL) tick();
        checks++;
        if (inPulseCnt != DEPTH) begin
            failures++;
            $display("[TB] FAIL rx_full_polls actual=%0d required=%0d", inPulseCnt, DEPTH);
        end
        busRead(BASE + 64'h10);
        checks++;
        if (rdata !== 64'hE || irq !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rx_full_status actual=0x%0h/%b required=0xe/1", rdata, irq);
        end
        busRead(BASE + 64'h8);
        checks++;
        if (rdata !== {56'b0, v}) begin
            failures++;
            $display("[TB] FAIL rx_full_head actual=0x%0h required=0x%0h", rdata, v);
        end
        for (int i = 0; i < POLL + 4 && inPulseCnt < DEPTH + 1; i++) tick();
        uartInCh = 8'hFF;
        checks++;
        if (inPulseCnt != DEPTH + 1) begin
            failures++;
            $display("[TB] FAIL rx_poll_resume actual=%0d required=%0d", inPulseCnt, DEPTH + 1);
        end
        for (int i = 0; i < DEPTH; i++) begin
            busRead(BASE + 64'h8);
            checks++;
            if (rdata !== {56'b0, v}) begin
                failures++;
                $display("[TB] FAIL rx_full_drain[%0d] actual=0x%0h required=0x%0h", i, rdata, v);
            end
        end
        busRead(BASE + 64'h8);
        checks++;
        if (rvalid !== 1'b1 || rdata !== 64'h0) begin
            failures++;
            $display("[TB] FAIL rx_full_underflow actual=%b/0x%0h required=1/0x0", rvalid, rdata);
        end
    endtask

    task automatic test_reset_mid_send();
        bit found;
        doReset();
        repeat (3) busWrite(BASE, {56'b0, 8'($urandom_range(0, 255))}, 64'hFF);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (outValid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!found) begin
            failures++;
            $display("[TB] FAIL mid_send_start actual=no pulse required=pulse");
        end
        txObs.delete();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outValid !== 1'b0 || outCh !== 8'h0) begin
            failures++;
            $display("[TB] FAIL async_reset_out actual=%b/0x%0h required=0/0x0", outValid, outCh);
        end
        tick();
        tick();
        rst_n = 1'b1;
        repeat (40) tick();
        checks++;
        if (txObs.size() != 0) begin
            failures++;
            $display("[TB] FAIL reset_flush_tx actual=%0d chars required=0", txObs.size());
        end
        busRead(BASE + 64'h10);
        checks++;
        if (rdata !== 64'h2 || irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_flush_status actual=0x%0h/%b required=0x2/0", rdata, irq);
        end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_ignored();
        test_tx_overflow();
        test_rx_basic();
        test_rx_full();
        test_reset_mid_send();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
